// File: rtl/sound_cmd_writer.sv
// -----------------------------------------------------------------------------
// sound_cmd_writer
//
// Main-CPU-side writer for the 8-bit sound command latch polled by the sound
// Z80. Host commands are queued in a small FIFO and presented one at a time.
// Each command stays on the latch until the sound CPU has read it and
// HOLD_IRQS sound interrupts have elapsed. The idle code is then shown for
// GAP_IRQS interrupts before the next command is presented.
//
// Handshake: a host command is accepted on every rising clk edge where
// cmd_valid and cmd_ready are both high. cmd_valid may be raised at any time,
// and cmd_data must be stable while cmd_valid is high. cmd_ready is high
// whenever the FIFO holds fewer than DEPTH entries.
//
// Ports:
//   clk        system clock, rising edge
//   reset_n    asynchronous active-low reset
//   cmd_data   host command byte
//   cmd_valid  host offers cmd_data
//   cmd_ready  FIFO can accept a command
//   adr        sound-CPU address bus
//   rd_n       sound-CPU read strobe, active low
//   int_n      sound-CPU interrupt line, active low
//   latch_data value the sound CPU reads at LATCH_ADDR
//   busy       sequencer active or commands pending
//   fifo_count current FIFO occupancy
//   state_dbg  sequencer state (0 IDLE, 1 PRESENT, 2 HOLD, 3 GAP)
// -----------------------------------------------------------------------------
module sound_cmd_writer #(
    parameter int          DEPTH       = 4,
    parameter logic [15:0] LATCH_ADDR  = 16'h6000,
    parameter logic [7:0]  CLEAR_VALUE = 8'h00,
    parameter int          HOLD_IRQS   = 2,
    parameter int          GAP_IRQS    = 1
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [7:0]               cmd_data,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [15:0]              adr,
    input  logic                     rd_n,
    input  logic                     int_n,
    output logic [7:0]               latch_data,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic [1:0]               state_dbg
);

    localparam int AW = $clog2(DEPTH);

    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [7:0]    HOLD_N   = 8'(HOLD_IRQS);
    localparam logic [7:0]    GAP_N    = 8'(GAP_IRQS);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRESENT = 2'd1,
        ST_HOLD    = 2'd2,
        ST_GAP     = 2'd3
    } state_t;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    state_t          state_q, state_d;
    logic [7:0]      irq_cnt_q, irq_cnt_d;
    logic [7:0]      latch_q, latch_d;
    logic            rd_q, rd_d;
    logic            int_q, int_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW:0]     count_q, count_d;
    logic [7:0]      mem_q [DEPTH];
    logic [7:0]      mem_d [DEPTH];

    // -------------------------------------------------------------------------
    // Bus event detection
    // -------------------------------------------------------------------------
    logic rd_act;
    logic rd_ev;
    logic int_ev;
    logic push;
    logic pop;
    logic [7:0] head;
    logic [7:0] cnt_inc;

    always_comb begin
        rd_act  = ~rd_n & (adr == LATCH_ADDR);
        // Rising edge of rd_act: one event per Z80 read cycle, however long
        // the strobe stays low.
        rd_ev   = rd_act & ~rd_q;
        int_ev  = ~int_n & int_q;
        rd_d    = rd_act;
        int_d   = int_n;
        push    = cmd_valid & (count_q != FULL_CNT);
        head    = mem_q[rd_ptr_q];
        cnt_inc = irq_cnt_q + 8'd1;
    end

    // -------------------------------------------------------------------------
    // FIFO next-state
    // -------------------------------------------------------------------------
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = cmd_data;
            wr_ptr_d        = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        // Simultaneous push and pop leaves the occupancy unchanged.
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // -------------------------------------------------------------------------
    // Sequencer: next-state process
    // -------------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        irq_cnt_d = irq_cnt_q;
        latch_d   = latch_q;
        pop       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (count_q != '0) begin
                    pop     = 1'b1;
                    latch_d = head;
                    state_d = ST_PRESENT;
                end
            end
            ST_PRESENT: begin
                // Interrupts are ignored here; a read wins even if an irq
                // edge lands in the same cycle.
                if (rd_ev) begin
                    state_d   = ST_HOLD;
                    irq_cnt_d = 8'd0;
                end
            end
            ST_HOLD: begin
                if (HOLD_N == 8'd0) begin
                    latch_d   = CLEAR_VALUE;
                    irq_cnt_d = 8'd0;
                    state_d   = ST_GAP;
                end else if (int_ev) begin
                    if (cnt_inc == HOLD_N) begin
                        latch_d   = CLEAR_VALUE;
                        irq_cnt_d = 8'd0;
                        state_d   = ST_GAP;
                    end else begin
                        irq_cnt_d = cnt_inc;
                    end
                end
            end
            ST_GAP: begin
                if (GAP_N == 8'd0) begin
                    irq_cnt_d = 8'd0;
                    state_d   = ST_IDLE;
                end else if (int_ev) begin
                    if (cnt_inc == GAP_N) begin
                        irq_cnt_d = 8'd0;
                        state_d   = ST_IDLE;
                    end else begin
                        irq_cnt_d = cnt_inc;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Sequencer: state register (also holds FIFO control and edge detectors)
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            irq_cnt_q <= 8'd0;
            latch_q   <= CLEAR_VALUE;
            rd_q      <= 1'b0;
            int_q     <= 1'b1;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            irq_cnt_q <= irq_cnt_d;
            latch_q   <= latch_d;
            rd_q      <= rd_d;
            int_q     <= int_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
        end
    end

    // FIFO storage needs no reset: entries are only read once written.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    // -------------------------------------------------------------------------
    // Sequencer: output process
    // -------------------------------------------------------------------------
    always_comb begin
        cmd_ready  = (count_q != FULL_CNT);
        latch_data = latch_q;
        busy       = (state_q != ST_IDLE) | (count_q != '0);
        fifo_count = count_q;
        state_dbg  = state_q;
    end

endmodule

// File: tb/tb_sound_cmd_writer.sv
// -----------------------------------------------------------------------------
// Bench for sound_cmd_writer. Two instances: u0 with default parameters and
// u1 with HOLD_IRQS=0 / GAP_IRQS=0. Each latch_data change is checked in order
// against a queue of expected latch values filled when commands are issued.
// -----------------------------------------------------------------------------
module tb_sound_cmd_writer;

    localparam logic [7:0] CLR       = 8'h00;
    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_PRESENT = 2'd1;
    localparam logic [1:0] S_HOLD    = 2'd2;
    localparam logic [1:0] S_GAP     = 2'd3;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic reset_n;

    // ---------------- DUT signals ----------------
    logic [7:0]  cmd_data0, cmd_data1;
    logic        cmd_valid0, cmd_valid1;
    logic        cmd_ready0, cmd_ready1;
    logic [15:0] adr0, adr1;
    logic        rd_n0, rd_n1;
    logic        int_n0, int_n1;
    logic [7:0]  latch0, latch1;
    logic        busy0, busy1;
    logic [2:0]  count0, count1;
    logic [1:0]  state0, state1;

    sound_cmd_writer u0 (
        .clk(clk), .reset_n(reset_n),
        .cmd_data(cmd_data0), .cmd_valid(cmd_valid0), .cmd_ready(cmd_ready0),
        .adr(adr0), .rd_n(rd_n0), .int_n(int_n0),
        .latch_data(latch0), .busy(busy0), .fifo_count(count0),
        .state_dbg(state0)
    );

    sound_cmd_writer #(.HOLD_IRQS(0), .GAP_IRQS(0)) u1 (
        .clk(clk), .reset_n(reset_n),
        .cmd_data(cmd_data1), .cmd_valid(cmd_valid1), .cmd_ready(cmd_ready1),
        .adr(adr1), .rd_n(rd_n1), .int_n(int_n1),
        .latch_data(latch1), .busy(busy1), .fifo_count(count1),
        .state_dbg(state1)
    );

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;
    logic [7:0] exp0_q[$];
    logic [7:0] exp1_q[$];
    logic [7:0] prev0 = CLR;
    logic [7:0] prev1 = CLR;
    logic [7:0] e0, e1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Monitors: every latch change outside reset must match the next entry.
    always @(negedge clk) begin
        if (reset_n === 1'b1 && latch0 !== prev0) begin
            if (exp0_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL latch0_seq actual=%0h expected=none", latch0);
            end else begin
                e0 = exp0_q.pop_front();
                chk("latch0_seq", latch0, e0);
            end
            prev0 = latch0;
        end
    end

    always @(negedge clk) begin
        if (reset_n === 1'b1 && latch1 !== prev1) begin
            if (exp1_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL latch1_seq actual=%0h expected=none", latch1);
            end else begin
                e1 = exp1_q.pop_front();
                chk("latch1_seq", latch1, e1);
            end
            prev1 = latch1;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push0(input logic [7:0] d, input bit track);
        int w;
        w = 0;
        while (!cmd_ready0 && w < 50) begin
            tick(1);
            w++;
        end
        chk("push0_ready", cmd_ready0, 1'b1);
        cmd_data0  = d;
        cmd_valid0 = 1'b1;
        if (track) begin
            exp0_q.push_back(d);
            exp0_q.push_back(CLR);
        end
        tick(1);
        cmd_valid0 = 1'b0;
    endtask

    task automatic irq0();
        int_n0 = 1'b0;
        tick(1);
        int_n0 = 1'b1;
        tick(1);
    endtask

    task automatic read0(input logic [15:0] a, input int n);
        adr0  = a;
        rd_n0 = 1'b0;
        tick(n);
        rd_n0 = 1'b1;
        adr0  = 16'h0000;
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    logic [7:0] cmds [5];

    initial begin
        cmds = '{8'h12, 8'h05, 8'h21, 8'h07, 8'h30};
        cmd_data0 = 8'h00; cmd_valid0 = 1'b0; adr0 = 16'h0; rd_n0 = 1'b1; int_n0 = 1'b1;
        cmd_data1 = 8'h00; cmd_valid1 = 1'b0; adr1 = 16'h0; rd_n1 = 1'b1; int_n1 = 1'b1;
        reset_n = 1'b1;
        #2 reset_n = 1'b0;
        tick(3);
        reset_n = 1'b1;
        tick(2);

        // 1. Reset state; reads and irqs with nothing queued do nothing.
        chk("rst_latch", latch0, CLR);
        chk("rst_busy", busy0, 1'b0);
        chk("rst_ready", cmd_ready0, 1'b1);
        chk("rst_count", count0, 3'd0);
        chk("rst_state", state0, S_IDLE);
        read0(16'h6000, 2);
        irq0();
        irq0();
        chk("idle_latch", latch0, CLR);
        chk("idle_state", state0, S_IDLE);
        chk("idle_busy", busy0, 1'b0);

        // 2. Single command: latency, indefinite present, hold, gap.
        cmd_data0 = 8'h12;
        cmd_valid0 = 1'b1;
        exp0_q.push_back(8'h12);
        exp0_q.push_back(CLR);
        tick(1);
        cmd_valid0 = 1'b0;
        chk("t2_count_after_push", count0, 3'd1);
        chk("t2_latch_after_push", latch0, CLR);
        tick(1);
        chk("t2_latch_present", latch0, 8'h12);
        chk("t2_count_after_pop", count0, 3'd0);
        chk("t2_state_present", state0, S_PRESENT);
        repeat (10) irq0();
        chk("t2_latch_unread", latch0, 8'h12);
        chk("t2_state_unread", state0, S_PRESENT);
        read0(16'h6000, 1);
        chk("t2_state_hold", state0, S_HOLD);
        irq0();
        chk("t2_latch_hold1", latch0, 8'h12);
        irq0();
        chk("t2_latch_cleared", latch0, CLR);
        chk("t2_state_gap", state0, S_GAP);
        chk("t2_busy_gap", busy0, 1'b1);
        irq0();
        chk("t2_state_idle", state0, S_IDLE);
        chk("t2_busy_idle", busy0, 1'b0);

        // 3. Five back-to-back pushes; bad reads; hold/gap not shortened.
        for (int i = 0; i < 5; i++) begin
            chk("t3_ready", cmd_ready0, 1'b1);
            cmd_data0  = cmds[i];
            cmd_valid0 = 1'b1;
            exp0_q.push_back(cmds[i]);
            exp0_q.push_back(CLR);
            tick(1);
        end
        cmd_valid0 = 1'b0;
        chk("t3_count_full", count0, 3'd4);
        chk("t3_ready_full", cmd_ready0, 1'b0);
        chk("t3_latch_first", latch0, 8'h12);
        read0(16'h6001, 3);
        adr0 = 16'h6000;
        irq0();
        irq0();
        irq0();
        adr0 = 16'h0000;
        chk("t3_badread_latch", latch0, 8'h12);
        chk("t3_badread_state", state0, S_PRESENT);
        for (int k = 0; k < 5; k++) begin
            chk("t3_latch_cmd", latch0, cmds[k]);
            chk("t3_state_present", state0, S_PRESENT);
            if (k == 0) read0(16'h6000, 20);
            else        read0(16'h6000, 1);
            chk("t3_state_hold", state0, S_HOLD);
            irq0();
            read0(16'h6000, 1);
            chk("t3_hold_read_latch", latch0, cmds[k]);
            chk("t3_hold_read_state", state0, S_HOLD);
            irq0();
            chk("t3_latch_clear", latch0, CLR);
            read0(16'h6000, 1);
            chk("t3_gap_read_state", state0, S_GAP);
            irq0();
        end
        chk("t3_end_busy", busy0, 1'b0);
        chk("t3_end_count", count0, 3'd0);
        chk("t3_end_latch", latch0, CLR);

        // 4. Zero hold / zero gap instance.
        cmd_data1  = 8'hAA;
        cmd_valid1 = 1'b1;
        exp1_q.push_back(8'hAA);
        exp1_q.push_back(CLR);
        tick(1);
        cmd_data1 = 8'h55;
        exp1_q.push_back(8'h55);
        exp1_q.push_back(CLR);
        tick(1);
        cmd_valid1 = 1'b0;
        chk("t4_latch_aa", latch1, 8'hAA);
        chk("t4_count", count1, 3'd1);
        adr1  = 16'h6000;
        rd_n1 = 1'b0;
        tick(1);
        rd_n1 = 1'b1;
        adr1  = 16'h0000;
        chk("t4_state_hold", state1, S_HOLD);
        chk("t4_latch_hold", latch1, 8'hAA);
        tick(1);
        chk("t4_latch_clear", latch1, CLR);
        chk("t4_state_gap", state1, S_GAP);
        tick(1);
        chk("t4_latch_idle", latch1, CLR);
        chk("t4_state_idle", state1, S_IDLE);
        tick(1);
        chk("t4_latch_55", latch1, 8'h55);
        chk("t4_count_empty", count1, 3'd0);
        adr1  = 16'h6000;
        rd_n1 = 1'b0;
        tick(1);
        rd_n1 = 1'b1;
        adr1  = 16'h0000;
        tick(1);
        chk("t4_latch_clear2", latch1, CLR);
        tick(2);
        chk("t4_busy_end", busy1, 1'b0);

        // 5. Asynchronous reset while holding with two commands queued.
        exp0_q.push_back(8'h81);
        exp0_q.push_back(CLR);
        push0(8'h81, 1'b0);
        push0(8'h82, 1'b0);
        push0(8'h83, 1'b0);
        chk("t5_count", count0, 3'd2);
        chk("t5_latch", latch0, 8'h81);
        read0(16'h6000, 1);
        irq0();
        chk("t5_state_hold", state0, S_HOLD);
        #3 reset_n = 1'b0;
        #1;
        chk("t5_rst_latch", latch0, CLR);
        chk("t5_rst_count", count0, 3'd0);
        chk("t5_rst_busy", busy0, 1'b0);
        chk("t5_rst_ready", cmd_ready0, 1'b1);
        chk("t5_rst_state", state0, S_IDLE);
        tick(2);
        reset_n = 1'b1;
        tick(5);
        chk("t5_post_latch", latch0, CLR);
        chk("t5_post_busy", busy0, 1'b0);
        chk("t5_post_count", count0, 3'd0);
        push0(8'h44, 1'b1);
        tick(1);
        chk("t5_new_latch", latch0, 8'h44);
        read0(16'h6000, 1);
        irq0();
        irq0();
        irq0();
        chk("t5_new_busy", busy0, 1'b0);

        tick(2);
        chk("exp0_drained", exp0_q.size(), 0);
        chk("exp1_drained", exp1_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
